// File: rtl/bit_demux16_pkg.sv
// bit_demux16_pkg: shared state enum and width constants for the serial-to-parallel demux
package bit_demux16_pkg;
  localparam int W = 16;
  localparam int IW = 4;
  typedef enum logic {FILL, HOLD} state_t;
endpackage

// File: rtl/bit_demux16_dec.sv
// bit_demux16_dec: one-hot write enable for the out position selected by sel
module bit_demux16_dec
  import bit_demux16_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic [IW-1:0] sel,
  output logic [W-1:0]  we
);
  always_comb we = W'(1) << (LSB_FIRST ? sel : IW'(W - 1) - sel);
endmodule

// File: rtl/bit_demux16.sv
// bit_demux16: collects 16 serial bits into a parallel word with valid/ready on both sides
// Optional out_parity output enabled by BIT_DEMUX16_PARITY_EN.
module bit_demux16
  import bit_demux16_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] sel
`ifdef BIT_DEMUX16_PARITY_EN
  ,
  output logic          out_parity
`endif
);
  state_t state, state_n;
  logic [W-1:0] we, out_n;
  logic [IW-1:0] sel_n;
  bit_demux16_dec #(.LSB_FIRST(LSB_FIRST)) u_dec (.sel(sel), .we(we));
  assign out_valid = state == HOLD;
  assign in_ready = clr || state == FILL || out_ready;
  // In HOLD sel is always 0, so a consumed frame restarts from position 0 with no bubble.
  always_comb begin
    state_n = state;
    out_n = out;
    sel_n = sel;
    if (clr) begin
      state_n = FILL;
      out_n = '0;
      sel_n = '0;
    end else if (state == FILL || out_ready) begin
      out_n = (state == HOLD ? W'(0) : out) | (in_valid && in ? we : W'(0));
      sel_n = sel + IW'(in_valid);
      state_n = (state == FILL && in_valid && sel == IW'(W - 1)) ? HOLD : FILL;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
      out <= '0;
      sel <= '0;
    end else begin
      state <= state_n;
      out <= out_n;
      sel <= sel_n;
    end
  end
`ifdef BIT_DEMUX16_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_parity <= 1'b0;
    else out_parity <= ^out_n;
  end
`endif
endmodule

// File: tb/tb_bit_demux16.sv
// tb_bit_demux16: directed scoreboard bench driving an LSB-first and an MSB-first instance in parallel
module tb_bit_demux16;
  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, in = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, in_ready_m, out_valid_m;
  logic [15:0] out, out_m;
  logic [3:0] sel, sel_m;
`ifdef BIT_DEMUX16_PARITY_EN
  logic out_parity, out_parity_m;
`endif
  int checks = 0, errs = 0, idx = 0;
  logic [15:0] acc = '0, acc_m = '0;
  logic [31:0] q[$];
  logic [31:0] e;

  always #5 clk = ~clk;

  bit_demux16 #(.LSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in(in), .in_valid(in_valid), .in_ready(in_ready),
    .out(out), .out_valid(out_valid), .out_ready(out_ready), .sel(sel)
`ifdef BIT_DEMUX16_PARITY_EN
    , .out_parity(out_parity)
`endif
  );
  bit_demux16 #(.LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in(in), .in_valid(in_valid), .in_ready(in_ready_m),
    .out(out_m), .out_valid(out_valid_m), .out_ready(out_ready), .sel(sel_m)
`ifdef BIT_DEMUX16_PARITY_EN
    , .out_parity(out_parity_m)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Output transfers are scored on the falling edge, before the edge that commits them.
  task automatic tick();
    @(negedge clk);
    if (out_valid && out_ready && !clr) begin
      chk("sb_nonempty", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_out", {out_m, out}, e);
        chk("sb_valid_m", 32'(out_valid_m), 32'd1);
`ifdef BIT_DEMUX16_PARITY_EN
        chk("sb_parity", {31'd0, out_parity}, {31'd0, ^e[15:0]});
        chk("sb_parity_m", {31'd0, out_parity_m}, {31'd0, ^e[31:16]});
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    acc = '0;
    acc_m = '0;
    idx = 0;
  endtask

  task automatic send_bit(input logic b);
    in = b;
    in_valid = 1'b1;
    acc[idx] = b;
    acc_m[15-idx] = b;
    idx++;
    if (idx == 16) begin
      q.push_back({acc_m, acc});
      model_reset();
    end
    tick();
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 0; i < 16; i++) send_bit(w[i]);
  endtask

  initial begin
    #12;
    chk("rst_out", {out_m, out}, 32'd0);
    chk("rst_valid", {30'd0, out_valid_m, out_valid}, 32'd0);
    chk("rst_sel", {24'd0, sel_m, sel}, 32'd0);
    chk("rst_ready", {30'd0, in_ready_m, in_ready}, 32'd3);
`ifdef BIT_DEMUX16_PARITY_EN
    chk("rst_parity", {30'd0, out_parity_m, out_parity}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // stream 0F0D: partial view after 4 bits, then full frame
    for (int i = 0; i < 4; i++) send_bit(16'h0F0D >> i);
    chk("partial_out", {out_m, out}, {16'hB000, 16'h000D});
    chk("partial_sel", {24'd0, sel_m, sel}, {24'd0, 4'd4, 4'd4});
    chk("partial_valid", 32'(out_valid), 32'd0);
    for (int i = 4; i < 16; i++) send_bit(16'h0F0D >> i);
    in_valid = 1'b0;
    chk("f1_valid", {30'd0, out_valid_m, out_valid}, 32'd3);
    chk("f1_out", {out_m, out}, {16'hB0F0, 16'h0F0D});
    chk("f1_sel", {24'd0, sel_m, sel}, 32'd0);
`ifdef BIT_DEMUX16_PARITY_EN
    chk("f1_parity", 32'(out_parity), 32'd1);
`endif
    tick();
    chk("drain_out", {out_m, out}, 32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);
    send_word(16'h00FF);
    in_valid = 1'b0;
    chk("f2_out", {out_m, out}, {16'hFF00, 16'h00FF});
`ifdef BIT_DEMUX16_PARITY_EN
    chk("f2_parity", 32'(out_parity), 32'd0);
`endif
    tick();
    // held frame with in_valid asserted must not accept bits
    out_ready = 1'b0;
    send_word(16'h0F0D);
    in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("hold_ready", {30'd0, in_ready_m, in_ready}, 32'd0);
      chk("hold_out", {out_m, out}, {16'hB0F0, 16'h0F0D});
      chk("hold_sel", {24'd0, sel_m, sel}, 32'd0);
      chk("hold_valid", 32'(out_valid), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    send_bit(1'b1);
    chk("resume_out", {out_m, out}, {16'h8000, 16'h0001});
    chk("resume_sel", {24'd0, sel_m, sel}, {24'd0, 4'd1, 4'd1});
    chk("resume_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 6; i++) send_bit(i[0] ? 1'b0 : 1'b1);
    chk("pre_clr_sel", 32'(sel), 32'd7);
    clr = 1'b1;
    in = 1'b1;
    chk("clr_ready", {30'd0, in_ready_m, in_ready}, 32'd3);
    tick();
    clr = 1'b0;
    model_reset();
    chk("clr_out", {out_m, out}, 32'd0);
    chk("clr_sel", {24'd0, sel_m, sel}, 32'd0);
    chk("clr_valid", 32'(out_valid), 32'd0);
    send_word(16'hFFFF);
    in_valid = 1'b0;
    chk("ones_out", {out_m, out}, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) tick();
    chk("ones_once", 32'(out_valid), 32'd0);
    // asynchronous reset mid-frame
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out", {out_m, out}, 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_sel", {24'd0, sel_m, sel}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    send_word(16'hFFFF);
    in_valid = 1'b0;
    chk("post_rst_out", {out_m, out}, 32'hFFFF_FFFF);
    tick();
    tick();
    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end
endmodule
